// File: rtl/fetch_pc_sequencer.sv
// IF-stage PC sequencer: drives the instruction-memory handshake, redirects on branch/jump and squashes wrong-path fetches.
// Optional build macro BRANCH_DELAY_SLOT_EN keeps the instruction accepted at redirect time (MIPS delay slot).
module fetch_pc_sequencer #(
  parameter int                   PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0,
  parameter int                   PC_STEP  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inStall,
  input  logic                inJumpValid,
  input  logic [PC_WIDTH-1:0] inJumpTarget,
  input  logic                inBranchValid,
  input  logic [PC_WIDTH-1:0] inBranchTarget,
  input  logic                inImemReady,
  output logic                outImemReq,
  output logic [PC_WIDTH-1:0] outImemAddr,
  output logic [PC_WIDTH-1:0] outPc,
  output logic [PC_WIDTH-1:0] outPostPc,
  output logic                outInstrValid,
  output logic                outFlush
);

  // state    | meaning
  // IDLE     | first cycle after reset, no request yet
  // FETCH    | request at pc, accept when memory is ready
  // WAIT     | memory not ready, hold request and address
  // REDIRECT | one dead cycle while pc is loaded with the target
  typedef enum logic [1:0] {IDLE, FETCH, WAIT, REDIRECT} state_t;

  localparam logic [PC_WIDTH-1:0] STEP       = PC_WIDTH'(PC_STEP);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~(PC_WIDTH'(3));

  state_t              state, stateNext;
  logic [PC_WIDTH-1:0] pc, pcNext;
  logic [PC_WIDTH-1:0] pcOut, pcOutNext;
  logic                valid, validNext;
  logic                redirect;
  logic [PC_WIDTH-1:0] target;

  // The branch comes from the older EX instruction, so it wins over the ID jump.
  assign redirect = inBranchValid | inJumpValid;
  assign target   = (inBranchValid ? inBranchTarget : inJumpTarget) & ALIGN_MASK;

  always_comb begin
    stateNext = state;
    pcNext    = pc;
    pcOutNext = pcOut;
    validNext = valid;
    case (state)
      IDLE: begin
        stateNext = FETCH;
        validNext = 1'b0;
      end
      FETCH, WAIT: begin
        if (redirect) begin
          pcNext    = target;
          stateNext = REDIRECT;
`ifdef BRANCH_DELAY_SLOT_EN
          if (inImemReady) begin
            pcOutNext = pc;
            validNext = 1'b1;
          end else begin
            validNext = 1'b0;
          end
`else
          validNext = 1'b0;
`endif
        end else if (inStall) begin
          stateNext = state;
        end else if (inImemReady) begin
          pcOutNext = pc;
          validNext = 1'b1;
          pcNext    = pc + STEP;
          stateNext = FETCH;
        end else begin
          validNext = 1'b0;
          stateNext = WAIT;
        end
      end
      REDIRECT: begin
        stateNext = FETCH;
        validNext = 1'b0;
      end
      default: begin
        stateNext = IDLE;
        validNext = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
      pcOut <= RESET_PC;
      valid <= 1'b0;
    end else begin
      state <= stateNext;
      pc    <= pcNext;
      pcOut <= pcOutNext;
      valid <= validNext;
    end
  end

  assign outImemReq    = (state == FETCH) || (state == WAIT);
  assign outImemAddr   = pc;
  assign outPc         = pcOut;
  assign outPostPc     = pcOut + STEP;
  assign outInstrValid = valid;
`ifdef BRANCH_DELAY_SLOT_EN
  assign outFlush      = 1'b0;
`else
  assign outFlush      = (state == REDIRECT) && !reset;
`endif

endmodule
